// File: rtl/if_id_hazard_ctrl_pkg.sv
// Shared definitions for the IF/ID hazard and redirect controller:
// FSM encoding, the hard-wired zero register and the ID/EX NOP control word.
package if_id_hazard_ctrl_pkg;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } id_ex_ctrl_t;

  // Selected into ID/EX by the bubble mux whenever id_ex_bubble is high.
  localparam id_ex_ctrl_t NOP_CTRL = '0;

  // $0 is hard-wired, so a zero destination never matches a source.
  function automatic logic reg_match(input logic [4:0] rd,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (rd != REG_ZERO) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

endpackage

// File: rtl/if_id_hazard_ctrl_hazard_cmp.sv
// Combinational hazard comparators: load-use against EX, and branch operand
// hazards against any EX writer or a MEM-stage load.
module if_id_hazard_ctrl_hazard_cmp
  import if_id_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_rd,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_rd,
  output logic       lu_haz,
  output logic       br_haz
);

  logic ex_match;
  logic mem_match;

  always_comb begin
    ex_match  = reg_match(ex_rd, id_rs, id_rt, id_uses_rt);
    mem_match = reg_match(mem_rd, id_rs, id_rt, id_uses_rt);
    lu_haz    = ex_mem_read & ex_match;
    // Branches resolve in ID, so they also wait on ALU results still in EX.
    br_haz    = id_is_branch & ((ex_reg_write & ex_match) | (mem_mem_read & mem_match));
  end

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID hazard and redirect controller: stall/bubble generation, a one-cycle
// flop-driven IF/ID flush on redirects, and saturating stall/flush statistics.
module if_id_hazard_ctrl
  import if_id_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_aclr,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_timeout
);

  localparam int STREAK_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(TIMEOUT);

  logic [0:0]          state_q, state_d;
  logic                aclr_q, aclr_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                timeout_q, timeout_d;

  logic lu_haz, br_haz, haz, redirect, run, stall_req, run_stall, run_redirect;

  if_id_hazard_ctrl_hazard_cmp hazard_cmp (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_is_branch(id_is_branch),
    .ex_mem_read (ex_mem_read),
    .ex_reg_write(ex_reg_write),
    .ex_rd       (ex_rd),
    .mem_mem_read(mem_mem_read),
    .mem_rd      (mem_rd),
    .lu_haz      (lu_haz),
    .br_haz      (br_haz)
  );

  // Redirect outranks an instruction-memory wait: the fetched word is discarded anyway.
  always_comb begin
    haz          = lu_haz | br_haz;
    redirect     = ~haz & (jump | (id_is_branch & branch_taken));
    run          = (state_q == ST_RUN);
    stall_req    = haz | (~redirect & ~imem_ready);
    run_stall    = run & stall_req;
    run_redirect = run & redirect;
    pc_write     = rst & run & ~stall_req;
    if_id_write  = pc_write;
    id_ex_bubble = ~pc_write;
    if_id_aclr   = aclr_q;
  end

  always_comb begin
    state_d     = ST_RUN;
    aclr_d      = 1'b0;
    if (run_redirect) begin
      state_d = ST_FLUSH;
      aclr_d  = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (run_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;

    flush_cnt_d = flush_cnt_q;
    if (run_redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;

    // Streak is held at TIMEOUT so a very long stall cannot wrap it.
    streak_d = '0;
    if (run_stall) streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;

    timeout_d = timeout_q | (streak_d == STREAK_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      aclr_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      streak_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      aclr_q      <= aclr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      streak_q    <= streak_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign stall_timeout = timeout_q;

endmodule
